// File: rtl/ram_master_pkg.sv
// Shared types and constants for the RAM burst master and its read FIFO.
package ram_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry {last,data} FIFO; the head entry is a register that drives the
// read stream directly so held data never glitches under backpressure.
module ram_rd_skid_fifo
    import ram_master_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pushLast_i,
    input  logic [DWIDTH-1:0]  pushData_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DWIDTH-1:0]  data_o,
    output logic               last_o,
    output logic [FIFO_CW-1:0] count_o
);

    logic [DWIDTH-1:0]  headData_q, headData_d;
    logic [DWIDTH-1:0]  tailData_q, tailData_d;
    logic               headLast_q, headLast_d;
    logic               tailLast_q, tailLast_d;
    logic [FIFO_CW-1:0] count_q, count_d;
    logic               pop;

    assign valid_o = (count_q != '0);
    assign data_o  = headData_q;
    assign last_o  = headLast_q;
    assign count_o = count_q;
    assign pop     = valid_o & ready_i;

    // New words land in the head when it is free, otherwise behind it.
    always_comb begin
        headData_d = headData_q;
        headLast_d = headLast_q;
        tailData_d = tailData_q;
        tailLast_d = tailLast_q;
        count_d    = count_q;
        unique case ({push_i, pop})
            2'b10: begin
                if (count_q == '0) begin
                    headData_d = pushData_i;
                    headLast_d = pushLast_i;
                end else begin
                    tailData_d = pushData_i;
                    tailLast_d = pushLast_i;
                end
                count_d = count_q + FIFO_CW'(1);
            end
            2'b01: begin
                headData_d = tailData_q;
                headLast_d = tailLast_q;
                count_d    = count_q - FIFO_CW'(1);
            end
            2'b11: begin
                if (count_q == FIFO_CW'(1)) begin
                    headData_d = pushData_i;
                    headLast_d = pushLast_i;
                end else begin
                    headData_d = tailData_q;
                    headLast_d = tailLast_q;
                    tailData_d = pushData_i;
                    tailLast_d = pushLast_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            headData_q <= '0;
            headLast_q <= 1'b0;
            tailData_q <= '0;
            tailLast_q <= 1'b0;
            count_q    <= '0;
        end else begin
            headData_q <= headData_d;
            headLast_q <= headLast_d;
            tailData_q <= tailData_d;
            tailLast_q <= tailLast_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous-read RAM: one command becomes
// a run of consecutive word accesses fed from / delivered to valid/ready streams.
module ram_burst_master
    import ram_master_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    output logic              mem_we,
    input  logic [DWIDTH-1:0] mem_dout
);

    localparam int DEPTH = 1 << AWIDTH;

    state_e             state_q, state_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic [AWIDTH-1:0]  cnt_q, cnt_d;
    logic               inflight_q, inflight_d;
    logic               inflightLast_q, inflightLast_d;
    logic               done_q, done_d;

    logic [AWIDTH-1:0]  addrNext;
    logic [FIFO_CW-1:0] fifoCount;
    logic [2:0]         occupancy;
    logic               fifoPop;
    logic               issue;
    logic               wrBeat;

    assign addrNext = AWIDTH'((32'(addr_q) + 32'd1) % DEPTH);
    assign fifoPop  = rd_valid & rd_ready;
    assign wrBeat   = wr_ready & wr_valid;

    ram_rd_skid_fifo #(.DWIDTH(DWIDTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (inflight_q),
        .pushLast_i (inflightLast_q),
        .pushData_i (mem_dout),
        .valid_o    (rd_valid),
        .ready_i    (rd_ready),
        .data_o     (rd_data),
        .last_o     (rd_last),
        .count_o    (fifoCount)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
        end
    end

    // The final read pop leaves the FIFO empty with nothing in flight, so it ends the drain.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        inflight_d     = issue;
        inflightLast_d = issue && (cnt_q == '0);
        done_d         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wrBeat) begin
                    addr_d = addrNext;
                    cnt_d  = cnt_q - AWIDTH'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addrNext;
                    cnt_d  = cnt_q - AWIDTH'(1);
                    if (cnt_q == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifoPop && rd_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads only issue when the word they return is guaranteed a FIFO slot.
    always_comb begin
        occupancy = 3'(fifoCount) + 3'(inflight_q) - 3'(fifoPop);
        issue     = (state_q == READ) && (occupancy < 3'(FIFO_DEPTH));
        cmd_ready = (state_q == IDLE) && !done_q;
        busy      = (state_q != IDLE);
        wr_ready  = (state_q == WRITE);
        mem_we    = (state_q == WRITE) && wr_valid && !reset;
        mem_addr  = addr_q;
        mem_din   = wr_data;
        done      = done_q;
    end

endmodule
